data_cache_ctrl: RTL

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_array.sv | 45 ++++
 rtl/data_cache_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encoding and the default line count.
package dcache_pkg;

    localparam int LINES_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_MISS = 2'b01,
        WR_THRU = 2'b10
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one shared index,
// synchronous write that also sets the valid bit, asynchronous read.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    input  logic [29-IDX_W:0] wr_tag,
    input  logic [31:0]       wr_data,
    output logic              rd_valid,
    output logic [29-IDX_W:0] rd_tag,
    output logic [31:0]       rd_data
);

    logic [LINES-1:0]  valid;
    logic [29-IDX_W:0] tags  [LINES];
    logic [31:0]       words [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
        end
    end

    // NOTE: only the valid bits need a reset; tag/data are never read while invalid,
    // and leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx]  <= wr_tag;
            words[idx] <= wr_data;
        end
    end

    assign rd_valid = valid[idx];
    assign rd_tag   = tags[idx];
    assign rd_data  = words[idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the saturating HitCount/MissCount outputs.
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HitCount,
    output logic [15:0] MissCount
`endif
);

    state_t            state, state_next;
    logic              arr_we;
    logic [31:0]       arr_wdata;
    logic              line_valid;
    logic [29-IDX_W:0] line_tag;
    logic [31:0]       line_data;
    logic              hit;
    logic              unused_adr_lsbs;

    assign unused_adr_lsbs = ^DataAdr[1:0];

    dcache_array #(.LINES(LINES), .IDX_W(IDX_W)) u_array (
        .clk      (clk),
        .reset    (reset),
        .idx      (DataAdr[IDX_W+1:2]),
        .we       (arr_we),
        .wr_tag   (DataAdr[31:IDX_W+2]),
        .wr_data  (arr_wdata),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    // The core holds its request while stalled, so DataAdr always names the pending line.
    assign hit = line_valid && (line_tag == DataAdr[31:IDX_W+2]);

    // NOTE: state register uses non-blocking assignment; all decode lives in always_comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        MemAdr     = {DataAdr[31:2], 2'b00};
        MemWData   = WriteData;
        ReadData   = line_data;
        arr_we     = 1'b0;
        arr_wdata  = WriteData;
        unique case (state)
            IDLE: begin
                if (MemWrite) begin
                    Stall      = 1'b1;
                    state_next = WR_THRU;
                end else if (MemRead && !hit) begin
                    Stall      = 1'b1;
                    state_next = RD_MISS;
                end
            end
            RD_MISS: begin
                MemReq = 1'b1;
                Stall  = 1'b1;
                if (MemAck) begin
                    arr_we     = 1'b1;
                    arr_wdata  = MemRData;
                    ReadData   = MemRData;
                    Stall      = 1'b0;
                    state_next = IDLE;
                end
            end
            WR_THRU: begin
                MemReq = 1'b1;
                MemWe  = 1'b1;
                Stall  = 1'b1;
                if (MemAck) begin
                    arr_we     = hit;
                    Stall      = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic rd_lookup;
    assign rd_lookup = (state == IDLE) && MemRead && !MemWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if (rd_lookup && hit && HitCount != 16'hFFFF) begin
                HitCount <= HitCount + 16'd1;
            end
            if (rd_lookup && !hit && MissCount != 16'hFFFF) begin
                MissCount <= MissCount + 16'd1;
            end
        end
    end
`endif

endmodule
